// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared geometry, state encoding and byte helpers for the data cache
package data_cache_pkg;

   localparam int TAG_W      = 3;
   localparam int INDEX_W    = 3;
   localparam int OFFSET_W   = 2;
   localparam int NUM_BLOCKS = 8;
   localparam int BLOCK_W    = 32;
   localparam int MADDR_W    = TAG_W + INDEX_W;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      FETCH     = 2'd2
   } cache_state_t;

   // Pick one byte out of a block; byte 0 lives in bits [7:0].
   function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                           input logic [OFFSET_W-1:0] off);
      logic [7:0] b;
      case (off)
         2'd0:    b = blk[7:0];
         2'd1:    b = blk[15:8];
         2'd2:    b = blk[23:16];
         default: b = blk[31:24];
      endcase
      return b;
   endfunction

   // Return a copy of a block with one byte replaced.
   function automatic logic [BLOCK_W-1:0] set_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFFSET_W-1:0] off,
                                                   input logic [7:0]          val);
      logic [BLOCK_W-1:0] r;
      r = blk;
      case (off)
         2'd0:    r[7:0]   = val;
         2'd1:    r[15:8]  = val;
         2'd2:    r[23:16] = val;
         default: r[31:24] = val;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - miss-handling FSM and memory-side drivers for the data cache
module cache_ctrl
   import data_cache_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   input  logic               i_req,
   input  logic               i_hit,
   input  logic               i_dirty,
   input  logic [MADDR_W-1:0] i_block_addr,
   input  logic [TAG_W-1:0]   i_stored_tag,
   input  logic [BLOCK_W-1:0] i_stored_block,
   input  logic               i_mem_busywait,
   output logic               o_idle,
   output logic               o_fill,
   output logic [MADDR_W-1:0] o_lat_block_addr,
   output logic               o_mem_read,
   output logic               o_mem_write,
   output logic [MADDR_W-1:0] o_mem_address,
   output logic [BLOCK_W-1:0] o_mem_writedata
);

   cache_state_t       r_state;
   cache_state_t       w_next_state;
   logic [MADDR_W-1:0] r_block_addr;

   // State register; reset aborts any transfer in flight.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Track the CPU block address while idle so it is frozen once a miss is taken.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                r_block_addr <= '0;
      else if (r_state == IDLE) r_block_addr <= i_block_addr;
   end

   // Next-state and memory-side outputs; everything idles at zero.
   always_comb begin
      w_next_state    = r_state;
      o_fill          = 1'b0;
      o_mem_read      = 1'b0;
      o_mem_write     = 1'b0;
      o_mem_address   = '0;
      o_mem_writedata = '0;
      case (r_state)
         IDLE: begin
            if (i_req && !i_hit)
               w_next_state = i_dirty ? WRITEBACK : FETCH;
         end
         WRITEBACK: begin
            o_mem_write     = 1'b1;
            o_mem_address   = {i_stored_tag, r_block_addr[INDEX_W-1:0]};
            o_mem_writedata = i_stored_block;
            if (!i_mem_busywait) w_next_state = FETCH;
         end
         FETCH: begin
            o_mem_read    = 1'b1;
            o_mem_address = r_block_addr;
            if (!i_mem_busywait) begin
               o_fill       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   assign o_idle           = (r_state == IDLE);
   assign o_lat_block_addr = r_block_addr;

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - 8 x 4-byte direct-mapped write-back write-allocate data cache
module data_cache
   import data_cache_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   input  logic               read,
   input  logic               write,
   input  logic [7:0]         address,
   input  logic [7:0]         writedata,
   output logic [7:0]         readdata,
   output logic               busywait,
   output logic               mem_read,
   output logic               mem_write,
   output logic [MADDR_W-1:0] mem_address,
   output logic [BLOCK_W-1:0] mem_writedata,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_busywait
);

   logic [NUM_BLOCKS-1:0] r_valid;
   logic [NUM_BLOCKS-1:0] r_dirty;
   logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
   logic [BLOCK_W-1:0]    r_data [NUM_BLOCKS];

   logic                  w_idle;
   logic                  w_fill;
   logic [MADDR_W-1:0]    w_lat_block_addr;
   logic [INDEX_W-1:0]    w_index;
   logic [TAG_W-1:0]      w_tag;
   logic [OFFSET_W-1:0]   w_offset;
   logic                  w_req;
   logic                  w_hit;
   logic                  w_write_hit;

   // While idle the live CPU address selects the line; during a miss the frozen one does.
   assign w_index  = w_idle ? address[4:2] : w_lat_block_addr[INDEX_W-1:0];
   assign w_tag    = w_idle ? address[7:5] : w_lat_block_addr[MADDR_W-1:INDEX_W];
   assign w_offset = address[1:0];

   assign w_req       = read | write;
   assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_write_hit = w_idle && write && w_hit;

   // A simultaneous read+write is handled as a write; reads need no cycle at all.
   assign busywait = !RESET && (w_idle ? (w_req && !w_hit) : 1'b1);
   assign readdata = (!RESET && w_idle && w_hit) ? get_byte(r_data[w_index], w_offset) : 8'h00;

   // Line status: reset invalidates everything, a fill makes the line clean, a store dirties it.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (w_fill) begin
         r_valid[w_index] <= 1'b1;
         r_dirty[w_index] <= 1'b0;
      end else if (w_write_hit) begin
         r_dirty[w_index] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid bits gate their use.
   always_ff @(posedge CLK) begin
      if (w_fill) begin
         r_tag[w_index]  <= w_tag;
         r_data[w_index] <= mem_readdata;
      end else if (w_write_hit) begin
         r_data[w_index] <= set_byte(r_data[w_index], w_offset, writedata);
      end
   end

   cache_ctrl u_ctrl (
      .CLK              (CLK),
      .RESET            (RESET),
      .i_req            (w_req),
      .i_hit            (w_hit),
      .i_dirty          (r_dirty[w_index]),
      .i_block_addr     (address[7:2]),
      .i_stored_tag     (r_tag[w_index]),
      .i_stored_block   (r_data[w_index]),
      .i_mem_busywait   (mem_busywait),
      .o_idle           (w_idle),
      .o_fill           (w_fill),
      .o_lat_block_addr (w_lat_block_addr),
      .o_mem_read       (mem_read),
      .o_mem_write      (mem_write),
      .o_mem_address    (mem_address),
      .o_mem_writedata  (mem_writedata)
   );

endmodule
